// File: rtl/rtmq_timer_bank_pkg.sv
// Shared RTMQ header: default register width plus the channel-state and mode encodings
// used by the timer bank and its channel sub-module.
package rtmq_timer_bank_pkg;

    localparam int unsigned RTMQ_W_REG = 32;

    typedef enum logic {
        CH_IDLE = 1'b0,
        CH_RUN  = 1'b1
    } rtmq_ch_state_e;

    typedef enum logic {
        MODE_ONESHOT  = 1'b0,
        MODE_PERIODIC = 1'b1
    } rtmq_mode_e;

endpackage

// File: rtl/rtmq_timer_bank_chan.sv
// Single countdown channel: load/cancel, per-cycle decrement, one-shot or periodic reload,
// and a combinational expiry strobe valid in the cycle the count reads 1.
module rtmq_tim_chan
    import rtmq_timer_bank_pkg::*;
#(
    parameter int unsigned W_REG = RTMQ_W_REG
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_ld,
    input  logic [W_REG-1:0] i_ld_val,
    input  logic             i_ld_per,
    output logic [W_REG-1:0] o_cnt,
    output logic             o_exp
);

    rtmq_ch_state_e   r_state;
    rtmq_mode_e       r_mode;
    logic [W_REG-1:0] r_cnt;
    logic [W_REG-1:0] r_rld;
    logic             w_exp;

    assign w_exp = (r_state == CH_RUN) && (r_cnt == W_REG'(1));

    // A load in the expiry cycle wins over the reload/idle decision.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= CH_IDLE;
            r_mode  <= MODE_ONESHOT;
            r_cnt   <= '0;
            r_rld   <= '0;
        end else if (i_ld) begin
            if (i_ld_val != '0) begin
                r_state <= CH_RUN;
                r_mode  <= rtmq_mode_e'(i_ld_per);
                r_cnt   <= i_ld_val;
                r_rld   <= i_ld_val;
            end else begin
                r_state <= CH_IDLE;
                r_cnt   <= '0;
            end
        end else if (w_exp) begin
            if (r_mode == MODE_PERIODIC) begin
                r_cnt <= r_rld;
            end else begin
                r_state <= CH_IDLE;
                r_cnt   <= '0;
            end
        end else if (r_state == CH_RUN) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_cnt = r_cnt;
    assign o_exp = w_exp;

endmodule

// File: rtl/rtmq_timer_bank.sv
// RTMQ timer bank: free-running wall clock, N_CH countdown channels, sticky pending flags
// and the registered resume pulse to the flow controller.
module rtmq_timer_bank
    import rtmq_timer_bank_pkg::*;
#(
    parameter int unsigned W_REG = RTMQ_W_REG,
    parameter int unsigned N_CH  = 4,
    parameter int unsigned W_CH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wck_we,
    input  logic [W_REG-1:0]      wck_dat,
    input  logic                  tim_we,
    input  logic [W_CH-1:0]       tim_ch,
    input  logic [W_REG-1:0]      tim_dat,
    input  logic                  tim_per,
    input  logic [N_CH-1:0]       pnd_clr,
    input  logic                  f_hld,
    output logic [W_REG-1:0]      reg_wck,
    output logic [N_CH*W_REG-1:0] reg_tim,
    output logic [N_CH-1:0]       tim_pnd,
    output logic                  f_timout
);

    logic [W_REG-1:0] r_wck;
    logic [N_CH-1:0]  r_pnd;
    logic [N_CH-1:0]  r_pnd_d;
    logic             r_hld_d;
    logic             r_fto;
    logic [N_CH-1:0]  w_ld;
    logic [N_CH-1:0]  w_exp;
    logic             w_pnd_rise;
    logic             w_hld_rise;

    // Out-of-range channel indices match no instance and are dropped.
    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        assign w_ld[k] = tim_we && (tim_ch == W_CH'(k));

        rtmq_tim_chan #(
            .W_REG(W_REG)
        ) u_chan (
            .i_clk   (clk),
            .i_rst_n (rst_n),
            .i_ld    (w_ld[k]),
            .i_ld_val(tim_dat),
            .i_ld_per(tim_per),
            .o_cnt   (reg_tim[k*W_REG +: W_REG]),
            .o_exp   (w_exp[k])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wck <= '0;
        end else if (wck_we) begin
            r_wck <= wck_dat;
        end else begin
            r_wck <= r_wck + 1'b1;
        end
    end

    assign w_pnd_rise = |(r_pnd & ~r_pnd_d);
    assign w_hld_rise = f_hld & ~r_hld_d;

    // Expiry is ORed after the clear so a same-cycle clear cannot lose a fresh expiry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pnd   <= '0;
            r_pnd_d <= '0;
            r_hld_d <= 1'b0;
            r_fto   <= 1'b0;
        end else begin
            r_pnd   <= (r_pnd & ~pnd_clr) | w_exp;
            r_pnd_d <= r_pnd;
            r_hld_d <= f_hld;
            r_fto   <= f_hld & (w_pnd_rise | (w_hld_rise & (|r_pnd)));
        end
    end

    assign reg_wck  = r_wck;
    assign tim_pnd  = r_pnd;
    assign f_timout = r_fto;

endmodule

// File: tb/tb_rtmq_timer_bank.sv
// Bench for rtmq_timer_bank (W_REG=8, N_CH=4): directed scenarios plus random traffic,
// compared every cycle against a deadline-based reference model.
module tb_rtmq_timer_bank;

    localparam int unsigned W  = 8;
    localparam int unsigned N  = 4;
    localparam int unsigned WC = 4;

    logic            clk     = 1'b0;
    logic            rst_n   = 1'b1;
    logic            wck_we  = 1'b0;
    logic [W-1:0]    wck_dat = '0;
    logic            tim_we  = 1'b0;
    logic [WC-1:0]   tim_ch  = '0;
    logic [W-1:0]    tim_dat = '0;
    logic            tim_per = 1'b0;
    logic [N-1:0]    pnd_clr = '0;
    logic            f_hld   = 1'b0;
    logic [W-1:0]    reg_wck;
    logic [N*W-1:0]  reg_tim;
    logic [N-1:0]    tim_pnd;
    logic            f_timout;

    rtmq_timer_bank #(
        .W_REG(W),
        .N_CH (N),
        .W_CH (WC)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .wck_we  (wck_we),
        .wck_dat (wck_dat),
        .tim_we  (tim_we),
        .tim_ch  (tim_ch),
        .tim_dat (tim_dat),
        .tim_per (tim_per),
        .pnd_clr (pnd_clr),
        .f_hld   (f_hld),
        .reg_wck (reg_wck),
        .reg_tim (reg_tim),
        .tim_pnd (tim_pnd),
        .f_timout(f_timout)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: each active channel holds the absolute cycle of its next expiry.
    longint       m_t;
    longint       m_dl   [N];
    bit           m_act  [N];
    bit           m_per  [N];
    int unsigned  m_len  [N];
    logic [N-1:0] m_pnd;
    logic [N-1:0] m_pnd_prev;
    bit           m_hld_prev;
    bit           m_fto;
    logic [W-1:0] m_wck;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_t        = 0;
        m_pnd      = '0;
        m_pnd_prev = '0;
        m_hld_prev = 1'b0;
        m_fto      = 1'b0;
        m_wck      = '0;
        for (int k = 0; k < N; k++) begin
            m_dl[k]  = 0;
            m_act[k] = 1'b0;
            m_per[k] = 1'b0;
            m_len[k] = 0;
        end
    endtask

    task automatic model_edge();
        logic [N-1:0] fired;
        fired = '0;
        for (int k = 0; k < N; k++) begin
            fired[k] = m_act[k] && (m_dl[k] == m_t);
        end
        for (int k = 0; k < N; k++) begin
            if (tim_we && int'(tim_ch) == k) begin
                if (tim_dat != 0) begin
                    m_act[k] = 1'b1;
                    m_len[k] = int'(tim_dat);
                    m_per[k] = tim_per;
                    m_dl[k]  = m_t + longint'(tim_dat);
                end else begin
                    m_act[k] = 1'b0;
                end
            end else if (fired[k]) begin
                if (m_per[k]) m_dl[k] = m_t + longint'(m_len[k]);
                else          m_act[k] = 1'b0;
            end
        end
        m_fto      = f_hld && ((|(m_pnd & ~m_pnd_prev)) || (!m_hld_prev && (|m_pnd)));
        m_pnd_prev = m_pnd;
        m_pnd      = (m_pnd & ~pnd_clr) | fired;
        m_hld_prev = f_hld;
        m_wck      = wck_we ? wck_dat : W'(m_wck + 8'd1);
        m_t++;
    endtask

    task automatic check_all();
        longint rem;
        check("wck", longint'(reg_wck), longint'(m_wck));
        for (int k = 0; k < N; k++) begin
            rem = m_act[k] ? (m_dl[k] - m_t + 1) : 0;
            check($sformatf("tim%0d", k), longint'(reg_tim[k*W +: W]), rem);
        end
        check("pnd", longint'(tim_pnd), longint'(m_pnd));
        check("fto", longint'(f_timout), longint'(m_fto));
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
        tim_we  = 1'b0;
        wck_we  = 1'b0;
        pnd_clr = '0;
    endtask

    task automatic load(input int ch, input int val, input bit per);
        tim_we  = 1'b1;
        tim_ch  = WC'(ch);
        tim_dat = W'(val);
        tim_per = per;
    endtask

    initial begin
        model_reset();
        #1 rst_n = 1'b0;
        #11 check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // Wall clock from reset and through a full wrap
        repeat (260) cyc();
        wck_we  = 1'b1;
        wck_dat = 8'hFD;
        repeat (5) cyc();

        // One-shot ch0, hold asserted
        f_hld = 1'b1;
        load(0, 5, 1'b0);
        repeat (9) cyc();
        check("os_pnd0", longint'(tim_pnd[0]), 1);
        pnd_clr = 4'b0001;
        cyc();

        // Periodic ch1 with hold low, then raise hold, then clear and watch re-set
        f_hld = 1'b0;
        load(1, 3, 1'b1);
        repeat (6) cyc();
        check("per_nofto", longint'(f_timout), 0);
        f_hld = 1'b1;
        repeat (3) cyc();
        pnd_clr = 4'b0010;
        cyc();
        repeat (7) cyc();
        load(1, 0, 1'b0);
        cyc();
        pnd_clr = 4'b1111;
        repeat (3) cyc();

        // ch0/ch2 expire together; clear of ch0 in its expiry cycle
        load(0, 5, 1'b0);
        cyc();
        load(2, 4, 1'b0);
        repeat (4) cyc();
        pnd_clr = 4'b0001;
        cyc();
        check("sim_pnd0", longint'(tim_pnd[0]), 1);
        check("sim_pnd2", longint'(tim_pnd[2]), 1);
        repeat (3) cyc();
        pnd_clr = 4'b1111;
        cyc();

        // Cancel ch3 at count 2; out-of-range channel index ignored
        load(3, 6, 1'b0);
        repeat (5) cyc();
        load(3, 0, 1'b0);
        repeat (8) cyc();
        check("cancel_pnd3", longint'(tim_pnd[3]), 0);
        load(7, 9, 1'b1);
        repeat (3) cyc();

        // Reload in the expiry cycle
        load(1, 2, 1'b0);
        repeat (2) cyc();
        load(1, 4, 1'b1);
        repeat (10) cyc();

        // Asynchronous reset mid-count on periodic ch0
        load(0, 3, 1'b1);
        repeat (2) cyc();
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_all();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) cyc();
        check("post_rst_pnd", longint'(tim_pnd), 0);

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                load(int'($urandom_range(0, 7)),
                     ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 10)),
                     1'($urandom_range(0, 1)));
            end
            if ($urandom_range(0, 3) == 0) pnd_clr = N'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) f_hld = ~f_hld;
            if ($urandom_range(0, 31) == 0) begin
                wck_we  = 1'b1;
                wck_dat = W'($urandom_range(0, 255));
            end
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
